apb_lcd_8080_ctrl: RTL

APB slave that drives an 8080-style parallel LCD in hardware instead of by per-pin software toggling. Software pushes command or data words into a small FIFO. A timing state machine then sequences CS/RS/WR/DATA for each word with programmable setup, strobe and hold lengths. It sits on the same APB peripheral bus as the other custom peripherals and owns the LCD pins.

---
 rtl/apb_lcd_8080_ctrl_pkg.sv | 15 +
 rtl/apb_lcd_8080_ctrl_fifo.sv | 42 ++++
 rtl/apb_lcd_8080_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/apb_lcd_8080_ctrl_pkg.sv
// lcd_pkg: shared constants, FSM states and FIFO entry layout for the 8080 LCD controller
package lcd_pkg;
    localparam int OFF_CMD    = 'h00;
    localparam int OFF_DATA   = 'h04;
    localparam int OFF_CTRL   = 'h08;
    localparam int OFF_TIMING = 'h0C;
    localparam int OFF_STATUS = 'h10;
    localparam logic [11:0] TIMING_RST = 12'h111;
    localparam int ENTRY_W = 17;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} lcd_state_e;
    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } lcd_entry_t;
endpackage

// File: rtl/apb_lcd_8080_ctrl_fifo.sv
// lcd_cmd_fifo: synchronous command FIFO; pushes while full and pops while empty are dropped
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_level;
    logic             w_wr, w_rd;
    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];
    assign w_wr    = i_wr & ~o_full;
    assign w_rd    = i_rd & ~o_empty;
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd) r_level <= r_level + 1'b1;
            else if (w_rd && !w_wr) r_level <= r_level - 1'b1;
        end
    end
endmodule

// File: rtl/apb_lcd_8080_ctrl.sv
// apb_lcd_8080_ctrl: APB slave that queues LCD command/data words and strobes them out
// on an 8080-style bus with programmable setup/strobe/hold phases
module apb_lcd_8080_ctrl
    import lcd_pkg::*;
#(
    parameter int ADDRWIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           ECOREVNUM,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 LCD_CS,
    output logic                 LCD_RS,
    output logic                 LCD_WR,
    output logic                 LCD_RD,
    output logic                 LCD_RST,
    output logic                 LCD_BL_CTR,
    output logic [15:0]          LCD_DATA
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [ADDRWIDTH-3:0] w_word;
    logic                 w_is_cmd, w_is_data, w_is_ctrl, w_is_timing, w_is_status;
    logic                 w_push_addr, w_wen, w_push, w_pop, w_zero;
    logic                 w_full, w_empty, w_busy;
    logic [LW-1:0]        w_level;
    logic [31:0]          w_status, w_rdata;
    lcd_entry_t           w_push_entry, w_head;
    lcd_state_e           r_state, w_next;
    logic [3:0]           r_cnt, w_cnt_next, w_setup, w_strobe, w_hold;
    logic [1:0]           r_ctrl;
    logic [11:0]          r_timing;
    logic                 r_cs, r_wr, r_rs;
    logic [15:0]          r_data;
    logic                 w_unused;
    assign w_unused    = ^{ECOREVNUM, PADDR[1:0], PWDATA[31:16]};
    assign w_word      = PADDR[ADDRWIDTH-1:2];
    assign w_is_cmd    = w_word == (ADDRWIDTH-2)'(OFF_CMD / 4);
    assign w_is_data   = w_word == (ADDRWIDTH-2)'(OFF_DATA / 4);
    assign w_is_ctrl   = w_word == (ADDRWIDTH-2)'(OFF_CTRL / 4);
    assign w_is_timing = w_word == (ADDRWIDTH-2)'(OFF_TIMING / 4);
    assign w_is_status = w_word == (ADDRWIDTH-2)'(OFF_STATUS / 4);
    assign w_push_addr = w_is_cmd | w_is_data;
    // Stall is decided on the registered full flag, so a same-cycle pop does not let a push in
    assign PREADY      = ~(PSEL & PWRITE & w_push_addr & w_full);
    assign PSLVERR     = 1'b0;
    assign w_wen       = PSEL & PENABLE & PWRITE & PREADY;
    assign w_push      = w_wen & w_push_addr;
    assign w_push_entry = '{rs: w_is_data, data: PWDATA[15:0]};
    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_wr    (w_push),
        .i_wdata (w_push_entry),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ctrl   <= '0;
            r_timing <= TIMING_RST;
        end else begin
            if (w_wen && w_is_ctrl) r_ctrl <= PWDATA[1:0];
            if (w_wen && w_is_timing) r_timing <= PWDATA[11:0];
        end
    end
    assign w_busy   = (r_state != ST_IDLE) | ~w_empty;
    assign w_status = {23'd0, 5'(w_level), 1'b0, w_empty, w_full, w_busy};
    always_comb begin
        w_rdata = w_is_ctrl   ? {30'd0, r_ctrl}   :
                  w_is_timing ? {20'd0, r_timing} :
                  w_is_status ? w_status          : 32'd0;
    end
    assign PRDATA   = (PSEL & ~PWRITE) ? w_rdata : 32'd0;
    assign w_setup  = r_timing[3:0];
    assign w_strobe = r_timing[7:4];
    assign w_hold   = r_timing[11:8];
    assign w_zero   = r_cnt == 4'd0;
    // Phase lengths are sampled only when the counter is loaded
    always_comb begin
        w_next     = r_state;
        w_cnt_next = w_zero ? 4'd0 : r_cnt - 4'd1;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_next     = ST_SETUP;
                    w_cnt_next = w_setup;
                end
            end
            ST_SETUP: begin
                if (w_zero) begin
                    w_next     = ST_STROBE;
                    w_cnt_next = w_strobe;
                end
            end
            ST_STROBE: begin
                if (w_zero) begin
                    w_next     = ST_HOLD;
                    w_cnt_next = w_hold;
                end
            end
            default: begin
                if (w_zero) begin
                    w_pop      = ~w_empty;
                    w_next     = w_empty ? ST_IDLE : ST_SETUP;
                    w_cnt_next = w_empty ? 4'd0 : w_setup;
                end
            end
        endcase
    end
    // Pins are registered from the next state so they never glitch
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_wr    <= 1'b1;
            r_rs    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_cs    <= w_next == ST_IDLE;
            r_wr    <= w_next != ST_STROBE;
            if (w_pop) begin
                r_rs   <= w_head.rs;
                r_data <= w_head.data;
            end
        end
    end
    assign LCD_CS     = r_cs;
    assign LCD_WR     = r_wr;
    assign LCD_RS     = r_rs;
    assign LCD_DATA   = r_data;
    assign LCD_RD     = 1'b1;
    assign LCD_RST    = r_ctrl[0];
    assign LCD_BL_CTR = r_ctrl[1];
endmodule
